// File: rtl/if_id_buf_pkg.sv
// Shared widths, constants and operation encoding for the IF/ID instruction buffer.
package if_id_buf_pkg;

  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 2;

  // Widest bus the zero word can blank; sliced down to INST_W / ADDR_W at use.
  localparam int unsigned      MAX_W     = 128;
  localparam logic [MAX_W-1:0] ZERO_WORD = 128'd0;

  localparam logic EN   = 1'b1;
  localparam logic STOP = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch/decode handshake bundle for if_id_buf; slave is the buffer, master the surrounding pipeline.
interface if_id_buf_if #(
  parameter int INST_W = if_id_buf_pkg::INST_W_DEF,
  parameter int ADDR_W = if_id_buf_pkg::ADDR_W_DEF,
  parameter int DEPTH  = if_id_buf_pkg::DEPTH_DEF
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic [ADDR_W-1:0] in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, count
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, count
  );

endinterface

// File: rtl/if_id_buf_mem.sv
// Entry storage for if_id_buf: one synchronous write port, one asynchronous read port, never cleared.
module if_id_buf_mem #(
  parameter int DEPTH = if_id_buf_pkg::DEPTH_DEF,
  parameter int WIDTH = if_id_buf_pkg::INST_W_DEF + if_id_buf_pkg::ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  import if_id_buf_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents survive reset and flush, occupancy lives in the parent.
  always_ff @(posedge clk) begin
    if (we == EN) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_buf.sv
// IF/ID instruction buffer: small in-order FIFO between fetch and decode with flush.
// Optional empty-buffer bypass enabled by defining IF_ID_BUF_BYPASS_EN.
module if_id_buf #(
  parameter int INST_W = if_id_buf_pkg::INST_W_DEF,
  parameter int ADDR_W = if_id_buf_pkg::ADDR_W_DEF,
  parameter int DEPTH  = if_id_buf_pkg::DEPTH_DEF
) (
  input logic        clk,
  input logic        rst,
  if_id_buf_if.slave bus
);

  import if_id_buf_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = INST_W + ADDR_W;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic             mem_we_s;
  logic [ENT_W-1:0] rd_data_s;
  fifo_op_e         op_s;

  if_id_buf_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_q),
    .wdata ({bus.in_inst, bus.in_pc}),
    .raddr (rd_ptr_q),
    .rdata (rd_data_s)
  );

  // Handshakes and decode-side view of the head entry (or the live input when bypassing).
  always_comb begin
    empty_s      = (count_q == CNT_W'(0));
    bus.in_ready = (count_q == CNT_W'(DEPTH)) ? STOP : EN;
`ifdef IF_ID_BUF_BYPASS_EN
    bypass_s = empty_s && bus.in_valid;
    if (bus.flush) begin
      bus.out_valid = STOP;
    end else if (empty_s) begin
      bus.out_valid = bus.in_valid;
    end else begin
      bus.out_valid = EN;
    end
`else
    bypass_s      = STOP;
    bus.out_valid = empty_s ? STOP : EN;
`endif
    // A bypassed entry taken by decode this cycle never enters storage.
    push_s   = bus.in_valid && bus.in_ready && !(bypass_s && bus.out_ready);
    pop_s    = bus.out_valid && bus.out_ready && !empty_s;
    mem_we_s = push_s && !bus.flush;
    if (!bus.out_valid) begin
      bus.out_inst = ZERO_WORD[INST_W-1:0];
      bus.out_pc   = ZERO_WORD[ADDR_W-1:0];
    end else if (bypass_s) begin
      bus.out_inst = bus.in_inst;
      bus.out_pc   = bus.in_pc;
    end else begin
      bus.out_inst = rd_data_s[ENT_W-1:ADDR_W];
      bus.out_pc   = rd_data_s[ADDR_W-1:0];
    end
  end

  // Next pointer/occupancy; flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    op_s     = fifo_op_e'({push_s, pop_s});
    if (bus.flush) begin
      rd_ptr_d = PTR_W'(0);
      wr_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      case (op_s)
        OP_PUSH: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
        OP_POP: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
        OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        default: begin
          rd_ptr_d = rd_ptr_q;
          wr_ptr_d = wr_ptr_q;
          count_d  = count_q;
        end
      endcase
    end
  end

  // State registers; reset empties the buffer without touching storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= PTR_W'(0);
      wr_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.count = count_q;

endmodule
